alarm_sequencer: RTL
====================

// Module: alarm_sequencer
// PURPOSE
//  Timekeeping and alarm controller for the alarm-clock design. Derives a 1 s clock-enable
//  from the board clock (no derived clocks), keeps HH:MM:SS, and accepts time/alarm set
//  requests. Runs the alarm FSM (armed/ringing/snooze) that drives the buzzer.
//  Sits between the board clock input and the display/buzzer logic.
// PARAMETERS
//  CLK_HZ      50_000_000  reloje cycles per second tick (prescaler modulus); >= 2
//  SNOOZE_MIN  5           minutes spent in SNOOZE before re-ringing; 1..63
//  RING_MIN    1           minutes RINGING lasts without stop/snooze before auto re-arm; 1..63
// PORTS
//  reloje      in   1  board clock, all logic on posedge
//  rst_n       in   1  asynchronous active-low reset
//  run         in   1  1 = time advances; 0 = prescaler and time frozen
//  set_time    in   1  1-cycle pulse: load set_hh/set_mm as current time
//  set_alarm   in   1  1-cycle pulse: load set_hh/set_mm as alarm time
//  set_hh      in   5  hour value for set operations, 0..23
//  set_mm      in   6  minute value for set operations, 0..59
//  alarm_en    in   1  level; 0 forces FSM to IDLE
//  snooze      in   1  1-cycle pulse, honoured only in RINGING
//  stop        in   1  1-cycle pulse, honoured in RINGING or SNOOZE
//  hh          out  5  current hour, 0..23
//  mm          out  6  current minute, 0..59
//  ss          out  6  current second, 0..59
//  sec_tick    out  1  1-cycle pulse per elapsed second
//  set_ack     out  1  1-cycle pulse the cycle after an accepted set
//  set_err     out  1  1-cycle pulse the cycle after a rejected set (out-of-range value)
//  alarm_state out  2  0=IDLE 1=ARMED 2=RINGING 3=SNOOZE
//  buzzer      out  1  buzzer drive
// BEHAVIOUR
//  Reset: all outputs 0; time 00:00:00; alarm 00:00; prescaler 0; FSM IDLE.
//  Prescaler: counts 0..CLK_HZ-1 while run=1. At CLK_HZ-1 it wraps to 0 and sec_tick=1 that cycle.
//  Time: on sec_tick, ss++; 59->0 with mm++; mm 59->0 with hh++; hh 23->0. Outputs registered,
//   so they update the cycle after sec_tick. min_evt (internal) = sec_tick & ss==59.
//  Set: set_hh>23 or set_mm>59 -> no load, set_err next cycle. A valid set_time loads hh/mm,
//   clears ss and prescaler; set_ack next cycle. A valid set_alarm loads the alarm regs; set_ack
//   next cycle. Both pulses in one cycle: set_time wins and set_alarm is dropped (no ack/err).
//   A set overrides a same-cycle tick, and that tick is lost.
//  FSM (evaluated every cycle; alarm_en=0 -> IDLE from any state, highest priority):
//   IDLE    -> ARMED when alarm_en=1.
//   ARMED   -> RINGING on min_evt when next hh:mm == alarm hh:mm. A set_time landing on the alarm
//              time does not ring.
//   RINGING -> ARMED on stop; -> SNOOZE on snooze (load snooze_cnt=SNOOZE_MIN);
//              -> ARMED after RING_MIN min_evt's with no input. If stop and snooze arrive
//              together, stop wins.
//   SNOOZE  -> ARMED on stop; snooze_cnt-- on min_evt; -> RINGING when it reaches 0 (ring
//              timer restarts).
//  buzzer: in RINGING = 1 during even seconds (ss[0]==0), 0 otherwise; 0 in all other states
//   unless chime active.
//  run=0: no sec_tick, so no min_evt and no FSM timing. stop/snooze/alarm_en still act.
//  Reset mid-ring: buzzer low asynchronously with rst_n; all state re-initialised.
// CONFIGURATION
//  HOUR_CHIME_EN defined: on the min_evt where mm wraps 59->0, buzzer=1 for exactly CLK_HZ
//   cycles, unless FSM is RINGING (ring pattern takes precedence).
//  Undefined: no chime logic; buzzer driven only by RINGING.
// TESTING (sim with CLK_HZ=4)
//  Reset, run=1, 16 cycles -> sec_tick 4 times, ss=4, hh:mm=00:00.
//  set_time 23:59 then 60 s -> time 00:00:00, set_ack 1 cycle after set.
//  set_time hh=24 -> set_err pulse, time unchanged; set_time+set_alarm same cycle -> one set_ack only.
//  alarm 00:01, alarm_en=1, time 00:00:59 -> RINGING at rollover, buzzer toggles each second.
//  RINGING, snooze -> SNOOZE; after 5 min -> RINGING; stop -> ARMED, buzzer 0.
//  RINGING, no input for 1 min -> ARMED; alarm_en=0 in SNOOZE -> IDLE next cycle.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm-clock timekeeper: 1 s prescaler, HH:MM:SS counter, time/alarm set and alarm FSM.
// Optional hourly chime is compiled in when HOUR_CHIME_EN is defined.
module alarm_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 1
) (
    input  logic       reloje,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       sec_tick,
    output logic       set_ack,
    output logic       set_err,
    output logic [1:0] alarm_state,
    output logic       buzzer
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hh_q, hh_d, al_hh_q, al_hh_d;
    logic [5:0]    mm_q, mm_d, ss_q, ss_d, al_mm_q, al_mm_d;
    logic          tick_q, ack_q, ack_d, err_q, err_d;
    state_t        state_q, state_d;
    logic [5:0]    snooze_cnt_q, snooze_cnt_d, ring_cnt_q, ring_cnt_d;
    logic          buzzer_q, buzzer_d;

    logic          set_ok_s, time_load_s, alarm_load_s, tick_s, min_evt_s, hit_s;
    logic [4:0]    hh_nx_s;
    logic [5:0]    mm_nx_s;

    // Set decode, second tick and next-minute lookahead for the alarm compare
    always_comb begin
        set_ok_s     = (set_hh <= 5'd23) && (set_mm <= 6'd59);
        time_load_s  = set_time && set_ok_s;
        alarm_load_s = set_alarm && !set_time && set_ok_s;
        tick_s       = run && (presc_q == PRESC_MAX) && !time_load_s;
        min_evt_s    = tick_s && (ss_q == 6'd59);
        if (mm_q == 6'd59) begin
            mm_nx_s = 6'd0;
            hh_nx_s = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        end else begin
            mm_nx_s = mm_q + 6'd1;
            hh_nx_s = hh_q;
        end
        hit_s = min_evt_s && (hh_nx_s == al_hh_q) && (mm_nx_s == al_mm_q);
        ack_d = (set_time || set_alarm) && set_ok_s;
        err_d = (set_time || set_alarm) && !set_ok_s;
    end

    // Prescaler and time-of-day next values; a time load swallows a coincident tick
    always_comb begin
        presc_d = presc_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        al_hh_d = al_hh_q;
        al_mm_d = al_mm_q;
        if (time_load_s) begin
            presc_d = '0;
            hh_d    = set_hh;
            mm_d    = set_mm;
            ss_d    = 6'd0;
        end else if (run) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (ss_q == 6'd59) begin
                    ss_d = 6'd0;
                    mm_d = mm_nx_s;
                    hh_d = hh_nx_s;
                end else begin
                    ss_d = ss_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else begin
            presc_d = presc_q;
        end
        if (alarm_load_s) begin
            al_hh_d = set_hh;
            al_mm_d = set_mm;
        end else begin
            al_mm_d = al_mm_q;
        end
    end

    // Time, alarm and set-handshake registers
    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            hh_q    <= 5'd0;
            mm_q    <= 6'd0;
            ss_q    <= 6'd0;
            al_hh_q <= 5'd0;
            al_mm_q <= 6'd0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            al_hh_q <= al_hh_d;
            al_mm_q <= al_mm_d;
            tick_q  <= tick_s;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Alarm FSM state register with its minute counters
    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            snooze_cnt_q <= 6'd0;
            ring_cnt_q   <= 6'd0;
        end else begin
            state_q      <= state_d;
            snooze_cnt_q <= snooze_cnt_d;
            ring_cnt_q   <= ring_cnt_d;
        end
    end

    // Alarm FSM next state; alarm_en low overrides everything, stop beats snooze
    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        ring_cnt_d   = ring_cnt_q;
        if (!alarm_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (hit_s) begin
                        state_d    = ST_RING;
                        ring_cnt_d = 6'(RING_MIN);
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_RING: begin
                    if (stop) begin
                        state_d = ST_ARMED;
                    end else if (snooze) begin
                        state_d      = ST_SNOOZE;
                        snooze_cnt_d = 6'(SNOOZE_MIN);
                    end else if (min_evt_s) begin
                        if (ring_cnt_q <= 6'd1) begin
                            state_d = ST_ARMED;
                        end else begin
                            ring_cnt_d = ring_cnt_q - 6'd1;
                        end
                    end else begin
                        state_d = ST_RING;
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        state_d = ST_ARMED;
                    end else if (min_evt_s) begin
                        if (snooze_cnt_q <= 6'd1) begin
                            state_d    = ST_RING;
                            ring_cnt_d = 6'(RING_MIN);
                        end else begin
                            snooze_cnt_d = snooze_cnt_q - 6'd1;
                        end
                    end else begin
                        state_d = ST_SNOOZE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

`ifdef HOUR_CHIME_EN
    localparam int CW = $clog2(CLK_HZ + 1);
    localparam logic [CW-1:0] CHIME_LEN = CW'(CLK_HZ);
    localparam logic [CW-1:0] CHIME_ONE = CW'(1);
    logic [CW-1:0] chime_cnt_q, chime_cnt_d;

    // Buzzer from next-cycle state/seconds so it lines up with the displayed time
    always_comb begin
        if (min_evt_s && (mm_q == 6'd59)) begin
            chime_cnt_d = CHIME_LEN;
        end else if (chime_cnt_q != '0) begin
            chime_cnt_d = chime_cnt_q - CHIME_ONE;
        end else begin
            chime_cnt_d = chime_cnt_q;
        end
        if (state_d == ST_RING) begin
            buzzer_d = !ss_d[0];
        end else begin
            buzzer_d = (chime_cnt_d != '0);
        end
    end

    // Chime duration counter
    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            chime_cnt_q <= '0;
        end else begin
            chime_cnt_q <= chime_cnt_d;
        end
    end
`else
    // Buzzer from next-cycle state/seconds so it lines up with the displayed time
    always_comb begin
        if (state_d == ST_RING) begin
            buzzer_d = !ss_d[0];
        end else begin
            buzzer_d = 1'b0;
        end
    end
`endif

    // Buzzer register, cleared asynchronously by reset
    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= buzzer_d;
        end
    end

    assign hh          = hh_q;
    assign mm          = mm_q;
    assign ss          = ss_q;
    assign sec_tick    = tick_q;
    assign set_ack     = ack_q;
    assign set_err     = err_q;
    assign alarm_state = state_q;
    assign buzzer      = buzzer_q;

endmodule
